// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives a 1-cycle-latency imem,
// and buffers {inst, pc} pairs in a small FIFO handed to decode via valid/ready.
module fetch_unit #(
  parameter int                XLEN         = 32,
  parameter int                ILEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int                FIFO_DEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] fetch_pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;

  logic            pop, push;
  logic [CW:0]     occ;

  assign inst_valid = (count != '0) & ~redirect_valid;
  assign pop        = inst_valid & inst_ready;
  assign push       = inflight & ~redirect_valid;
  assign inst       = fifo_q[rd_ptr].inst;
  assign inst_pc    = fifo_q[rd_ptr].pc;
  assign imem_addr  = fetch_pc;

  // Reserve a slot for every outstanding request, crediting a same-cycle pop,
  // so the response always has room and full throughput holds at depth 2.
  assign occ     = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign imem_en = ~reset & ~redirect_valid & (occ < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~XLEN'(3);
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        fetch_pc    <= fetch_pc + XLEN'(4);
        inflight_pc <= fetch_pc;
      end
      if (push) begin
        fifo_q[wr_ptr] <= '{inst: imem_rdata, pc: inflight_pc};
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h100;

  logic        clk, reset, imem_en, redirect_valid, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.XLEN(32), .ILEN(32), .RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Synchronous memory, 1-cycle latency; junk when not read so stale use shows up.
  always @(posedge clk) imem_rdata <= imem_en ? mem_data(imem_addr) : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Reference model: next fetch PC, one outstanding-request slot, buffered PCs.
  bit          m_known = 0;
  logic [31:0] m_pc, m_ifpc;
  int          m_inflight;
  logic [31:0] q[$];
  logic [31:0] acc[$];

  always @(negedge clk) begin
    bit ev, pop, een;
    ev  = (q.size() != 0) && !redirect_valid;
    pop = ev && inst_ready;
    een = !reset && !redirect_valid && (q.size() + m_inflight - int'(pop) < DEPTH);
    if (m_known) begin
      chk("m_valid", {31'b0, inst_valid}, {31'b0, ev});
      chk("m_imem_en", {31'b0, imem_en}, {31'b0, een});
      if (!reset) chk("m_imem_addr", imem_addr, m_pc);
      if (ev) begin
        chk("m_inst_pc", inst_pc, q[0]);
        chk("m_inst", inst, mem_data(q[0]));
      end
      if (pop && !reset) acc.push_back(q[0]);
    end
    if (reset) begin
      m_pc = RV; m_inflight = 0; q = {}; m_known = 1;
    end else if (m_known) begin
      if (redirect_valid) begin
        m_pc = redirect_pc & ~32'd3; m_inflight = 0; q = {};
      end else begin
        if (pop) void'(q.pop_front());
        if (m_inflight != 0) q.push_back(m_ifpc);
        if (een) begin m_ifpc = m_pc; m_pc = m_pc + 32'd4; end
        m_inflight = int'(een);
      end
    end
  end

  task automatic set(input logic r, input logic v, input logic [31:0] p, input logic rd);
    reset = r; redirect_valid = v; redirect_pc = p; inst_ready = rd;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int n0;

  initial begin
    set(1, 0, 0, 1);
    tick(); tick();

    // Streaming from the reset vector
    set(0, 0, 0, 1); #3;
    chk("s1_en0", {31'b0, imem_en}, 1);
    chk("s1_addr0", imem_addr, 32'h100);
    chk("s1_v0", {31'b0, inst_valid}, 0);
    tick();
    #3; chk("s1_v1", {31'b0, inst_valid}, 0); chk("s1_addr1", imem_addr, 32'h104); tick();
    for (int k = 2; k < 8; k++) begin
      #3;
      chk("s1_v", {31'b0, inst_valid}, 1);
      chk("s1_pc", inst_pc, 32'h100 + 32'(4 * (k - 2)));
      chk("s1_inst", inst, mem_data(32'h100 + 32'(4 * (k - 2))));
      tick();
    end

    // Backpressure for 10 cycles, then release
    set(0, 0, 0, 0);
    for (int j = 0; j < 10; j++) begin
      #3;
      chk("s2_hold_pc", inst_pc, 32'h118);
      chk("s2_hold_v", {31'b0, inst_valid}, 1);
      if (j >= 2) chk("s2_en_low", {31'b0, imem_en}, 0);
      tick();
    end
    set(0, 0, 0, 1);
    for (int j = 0; j < 6; j++) begin
      #3;
      chk("s2_rel_pc", inst_pc, 32'h118 + 32'(4 * j));
      tick();
    end

    // Redirect with buffer full, a fetch in flight and decode ready
    n0 = acc.size();
    set(0, 1, 32'h2003, 1); #3;
    chk("s3_v_T", {31'b0, inst_valid}, 0);
    chk("s3_en_T", {31'b0, imem_en}, 0);
    tick();
    set(0, 0, 0, 1); #3;
    chk("s3_en_T1", {31'b0, imem_en}, 1);
    chk("s3_addr_T1", imem_addr, 32'h2000);
    chk("s3_v_T1", {31'b0, inst_valid}, 0);
    tick();
    #3; chk("s3_v_T2", {31'b0, inst_valid}, 0); chk("s3_addr_T2", imem_addr, 32'h2004); tick();
    #3; chk("s3_v_T3", {31'b0, inst_valid}, 1); chk("s3_pc_T3", inst_pc, 32'h2000); tick();
    #3;
    chk("s4_acc_n", 32'(acc.size()), 32'(n0 + 1));
    chk("s4_acc_pc", acc[acc.size() - 1], 32'h2000);
    tick();

    // Back-to-back redirects, last one wins; address wraps
    set(0, 1, 32'h3000, 1); tick();
    set(0, 1, 32'hFFFF_FFFF, 1); tick();
    set(0, 0, 0, 1); #3;
    chk("s5_addr_a", imem_addr, 32'hFFFF_FFFC);
    chk("s5_en_a", {31'b0, imem_en}, 1);
    tick();
    #3; chk("s5_addr_b", imem_addr, 32'h0); tick();
    #3; chk("s5_pc_a", inst_pc, 32'hFFFF_FFFC); chk("s5_inst_a", inst, mem_data(32'hFFFF_FFFC)); tick();
    #3; chk("s5_pc_b", inst_pc, 32'h0); tick();

    // Reset mid-stream with the buffer partly filled
    set(0, 0, 0, 0); tick();
    set(1, 0, 0, 1); tick();
    set(0, 0, 0, 1); #3;
    chk("s6_v", {31'b0, inst_valid}, 0);
    chk("s6_inst", inst, 32'h0);
    chk("s6_pc", inst_pc, 32'h0);
    chk("s6_addr", imem_addr, RV);
    chk("s6_en", {31'b0, imem_en}, 1);
    tick();
    #3; chk("s6_v1", {31'b0, inst_valid}, 0); tick();
    #3; chk("s6_v2", {31'b0, inst_valid}, 1); chk("s6_pc2", inst_pc, RV); tick();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
